data_stream_demux: RTL and testbench

- Receive-side stage directly downstream of the data-stream multiplexer.
- Takes the time-division-multiplexed 16-bit word stream and splits it back into up to three parallel streams (DS1..DS3).
- Slot timing uses the same mode/switch_clock_cycles programming as the multiplexer.
- Symbol boundaries are marked by a single-cycle strobe synchronous to clk, so the block runs on one clock.

---
 rtl/data_stream_demux.sv | 162 ++++++++++++++++
 tb/tb_data_stream_demux.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_stream_demux.sv
// Receive-side TDM demultiplexer: splits one word stream back into up to three parallel streams.
// Optional build macro DATA_STREAM_DEMUX_SYNC_ERR_EN adds sticky sync_err reporting with sync_err_clr.
module data_stream_demux #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        mode,
   input  logic [CNT_W-1:0]  switch_clock_cycles,
   input  logic              sym_strobe,
   input  logic [DATA_W-1:0] multiplexed_data,
`ifdef DATA_STREAM_DEMUX_SYNC_ERR_EN
   input  logic              sync_err_clr,
   output logic              sync_err,
`endif
   output logic [DATA_W-1:0] DS1_out,
   output logic [DATA_W-1:0] DS2_out,
   output logic [DATA_W-1:0] DS3_out,
   output logic              out_valid,
   output logic [1:0]        slot_idx
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t            state;
   logic [1:0]        num_slots;
   logic [1:0]        slot;
   logic [CNT_W-1:0]  slot_len;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] hold [3];

   logic              accept;
   logic              stop;
   logic              run_final;
   logic              act;
   logic              slot_end;
   logic              sym_end;
   logic [1:0]        eff_slot;
   logic [1:0]        eff_n;
   logic [CNT_W-1:0]  eff_cnt;
   logic [CNT_W-1:0]  eff_len;
   logic [CNT_W-1:0]  new_len;

   assign new_len   = (switch_clock_cycles == '0) ? CNT_ONE : switch_clock_cycles;
   assign stop      = sym_strobe && (mode == 2'b00);
   assign accept    = sym_strobe && (mode != 2'b00);
   assign run_final = (state == RUN) && (cnt == slot_len - CNT_ONE) && (slot == num_slots - 2'd1);
   assign slot_idx  = slot;

   // The strobe cycle is itself slot 0 / count 0 of the new symbol, except when it lands on the
   // final capture of the running symbol: that word completes the old symbol and the new one starts next cycle.
   always_comb begin
      act      = 1'b0;
      eff_slot = slot;
      eff_cnt  = cnt;
      eff_len  = slot_len;
      eff_n    = num_slots;
      if (stop) begin
         act = 1'b0;
      end else if (accept && !run_final) begin
         act      = 1'b1;
         eff_slot = 2'd0;
         eff_cnt  = '0;
         eff_len  = new_len;
         eff_n    = mode;
      end else if (state == RUN) begin
         act = 1'b1;
      end
      slot_end = act && (eff_cnt == eff_len - CNT_ONE);
      sym_end  = slot_end && (eff_slot == eff_n - 2'd1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         num_slots <= 2'd0;
         slot      <= 2'd0;
         slot_len  <= '0;
         cnt       <= '0;
         hold[0]   <= '0;
         hold[1]   <= '0;
         hold[2]   <= '0;
         DS1_out   <= '0;
         DS2_out   <= '0;
         DS3_out   <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= sym_end;
         if (slot_end) begin
            hold[eff_slot] <= multiplexed_data;
         end
         // The last slot's word bypasses hold so all streams update one clock after the final capture.
         if (sym_end) begin
            DS1_out <= (eff_n == 2'd1) ? multiplexed_data : hold[0];
            DS2_out <= (eff_n == 2'd2) ? multiplexed_data : ((eff_n == 2'd3) ? hold[1] : '0);
            DS3_out <= (eff_n == 2'd3) ? multiplexed_data : '0;
         end
         if (accept) begin
            num_slots <= mode;
            slot_len  <= new_len;
         end
         if (stop) begin
            state <= IDLE;
            slot  <= 2'd0;
            cnt   <= '0;
         end else if (accept && run_final) begin
            state <= RUN;
            slot  <= 2'd0;
            cnt   <= '0;
         end else if (act) begin
            if (sym_end) begin
               state <= WAIT;
               slot  <= 2'd0;
               cnt   <= '0;
            end else if (slot_end) begin
               state <= RUN;
               slot  <= eff_slot + 2'd1;
               cnt   <= '0;
            end else begin
               state <= RUN;
               slot  <= eff_slot;
               cnt   <= eff_cnt + CNT_ONE;
            end
         end
      end
   end

`ifdef DATA_STREAM_DEMUX_SYNC_ERR_EN
   localparam logic [CNT_W+1:0] WAIT_ONE = (CNT_W+2)'(1);

   logic [CNT_W+1:0] wait_cnt;
   logic [CNT_W+1:0] wait_limit;
   logic             err_set;

   assign wait_limit = (CNT_W+2)'(slot_len) * (CNT_W+2)'({1'b0, num_slots} + 3'd1);
   assign err_set    = (accept && (state == RUN) && !run_final) ||
                       ((state == WAIT) && !sym_strobe && (wait_cnt == wait_limit - WAIT_ONE));

   // Watchdog for a missing strobe: N*L+L cycles of WAIT without a new symbol start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         sync_err <= 1'b0;
      end else begin
         if ((state != WAIT) || sym_strobe) begin
            wait_cnt <= '0;
         end else if (wait_cnt != wait_limit) begin
            wait_cnt <= wait_cnt + WAIT_ONE;
         end
         sync_err <= err_set | (sync_err & ~sync_err_clr);
      end
   end
`endif

endmodule

// File: tb/tb_data_stream_demux.sv
// Self-checking bench for data_stream_demux: directed scenarios plus randomized traffic against
// a symbol-position reference model.
module tb_data_stream_demux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  mode;
   logic [31:0] switch_clock_cycles;
   logic        sym_strobe;
   logic [15:0] multiplexed_data;
   logic [15:0] DS1_out, DS2_out, DS3_out;
   logic        out_valid;
   logic [1:0]  slot_idx;
`ifdef DATA_STREAM_DEMUX_SYNC_ERR_EN
   logic        sync_err_clr = 1'b0;
   logic        sync_err;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: position within the symbol in clock cycles, plus latched N and L.
   bit          m_active;
   int          m_pos, m_n, m_l, m_slot;
   bit          m_valid;
   logic [15:0] m_hold [3];
   logic [15:0] m_ds [3];

   logic [50:0] dut_vec;
   assign dut_vec = {out_valid, slot_idx, DS1_out, DS2_out, DS3_out};

   always #5 clk = ~clk;

   data_stream_demux #(.DATA_W(16), .CNT_W(32)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .mode                (mode),
      .switch_clock_cycles (switch_clock_cycles),
      .sym_strobe          (sym_strobe),
      .multiplexed_data    (multiplexed_data),
`ifdef DATA_STREAM_DEMUX_SYNC_ERR_EN
      .sync_err_clr        (sync_err_clr),
      .sync_err            (sync_err),
`endif
      .DS1_out             (DS1_out),
      .DS2_out             (DS2_out),
      .DS3_out             (DS3_out),
      .out_valid           (out_valid),
      .slot_idx            (slot_idx)
   );

   function automatic logic [50:0] exp_vec();
      logic [1:0] s;
      s = m_slot[1:0];
      return {m_valid, s, m_ds[0], m_ds[1], m_ds[2]};
   endfunction

   function automatic void model_reset();
      m_active = 0; m_pos = 0; m_n = 0; m_l = 1; m_slot = 0; m_valid = 0;
      for (int k = 0; k < 3; k++) begin
         m_hold[k] = '0;
         m_ds[k]   = '0;
      end
   endfunction

   function automatic void model_consume(input logic [15:0] d);
      if (m_pos % m_l == m_l - 1) m_hold[m_pos / m_l] = d;
      if (m_pos == m_n * m_l - 1) begin
         for (int k = 0; k < 3; k++) m_ds[k] = (k < m_n) ? m_hold[k] : 16'd0;
         m_valid  = 1;
         m_active = 0;
         m_pos    = 0;
      end else begin
         m_pos++;
      end
   endfunction

   function automatic void model_step(input bit s, input logic [1:0] m, input int sw, input logic [15:0] d);
      bit fin;
      fin     = m_active && (m_pos == m_n * m_l - 1);
      m_valid = 0;
      if (s && m == 2'd0) begin
         m_active = 0;
         m_pos    = 0;
      end else if (s && !fin) begin
         m_n = int'(m); m_l = (sw == 0) ? 1 : sw; m_pos = 0; m_active = 1;
         model_consume(d);
      end else if (m_active) begin
         model_consume(d);
         if (s) begin
            m_n = int'(m); m_l = (sw == 0) ? 1 : sw; m_pos = 0; m_active = 1;
         end
      end
      m_slot = m_active ? m_pos / m_l : 0;
   endfunction

   task automatic drive(input bit s, input logic [1:0] m, input int sw, input logic [15:0] d);
      sym_strobe          = s;
      mode                = m;
      switch_clock_cycles = sw;
      multiplexed_data    = d;
      model_step(s, m, sw, d);
      @(posedge clk);
      #1;
      sym_strobe = 1'b0;
   endtask

   task automatic do_reset();
      sym_strobe = 0; mode = 0; switch_clock_cycles = 0; multiplexed_data = 0;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sym_strobe = 0; mode = 2'b11; switch_clock_cycles = 2; multiplexed_data = 16'hABCD;
      model_reset();
      #2;
      checks++;
      if (dut_vec !== 51'd0) begin
         errors++; $display("[TB] FAIL reset_async: got %h expected 0", dut_vec);
      end
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
         errors++; $display("[TB] FAIL reset_held: got %h expected %h", dut_vec, exp_vec());
      end
      rst_n = 1'b1;
   endtask

   task automatic test_two_streams();
      logic [15:0] w [6];
      w = '{16'd7, 16'd1, 16'd8, 16'd2, 16'd9, 16'd3};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(i % 2 == 0, 2'b10, 1, w[i]);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("[TB] FAIL two_streams_model cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         if (i % 2 == 1) begin
            checks++;
            if ({out_valid, DS1_out, DS2_out, DS3_out} !== {1'b1, w[i-1], w[i], 16'd0}) begin
               errors++; $display("[TB] FAIL two_streams_pair cyc %0d: got %b %0d %0d %0d expected 1 %0d %0d 0",
                                  i, out_valid, DS1_out, DS2_out, DS3_out, w[i-1], w[i]);
            end
         end
      end
   endtask

   task automatic test_three_streams();
      logic [15:0] w [6];
      int          seq [6];
      w   = '{16'd10, 16'd10, 16'd20, 16'd20, 16'd30, 16'd30};
      seq = '{0, 1, 1, 2, 2, 0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(i == 0, 2'b11, 2, w[i]);
         checks++;
         if ({out_valid, slot_idx} !== {i == 5, 2'(seq[i])}) begin
            errors++; $display("[TB] FAIL three_streams_slot cyc %0d: got valid=%b slot=%0d expected valid=%b slot=%0d",
                               i, out_valid, slot_idx, i == 5, seq[i]);
         end
      end
      checks++;
      if ({DS1_out, DS2_out, DS3_out} !== {16'd10, 16'd20, 16'd30}) begin
         errors++; $display("[TB] FAIL three_streams_data: got %0d %0d %0d expected 10 20 30", DS1_out, DS2_out, DS3_out);
      end
   endtask

   task automatic test_zero_len();
      logic [15:0] w;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         w = 16'($urandom);
         drive(1, 2'b01, 0, w);
         checks++;
         if ({out_valid, slot_idx, DS1_out, DS2_out, DS3_out} !== {1'b1, 2'd0, w, 16'd0, 16'd0}) begin
            errors++; $display("[TB] FAIL zero_len cyc %0d: got %h expected %h", i, dut_vec, {1'b1, 2'd0, w, 32'd0});
         end
      end
   endtask

   task automatic test_early_strobe();
      logic [15:0] w [14];
      do_reset();
      for (int i = 0; i < 14; i++) w[i] = 16'($urandom);
      for (int i = 0; i < 14; i++) begin
         drive(i == 0 || i == 6 || i == 8, 2'b11, 2, w[i]);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("[TB] FAIL early_model cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         if (i >= 6 && i <= 12) begin
            checks++;
            if ({out_valid, DS1_out} !== {1'b0, w[1]}) begin
               errors++; $display("[TB] FAIL early_hold cyc %0d: got valid=%b DS1=%h expected 0 %h", i, out_valid, DS1_out, w[1]);
            end
         end
      end
      checks++;
      if ({out_valid, DS1_out, DS2_out, DS3_out} !== {1'b1, w[9], w[11], w[13]}) begin
         errors++; $display("[TB] FAIL early_restart: got %b %h %h %h expected 1 %h %h %h",
                            out_valid, DS1_out, DS2_out, DS3_out, w[9], w[11], w[13]);
      end
   endtask

   task automatic test_mode_change();
      logic [15:0] w [5];
      logic [1:0]  m [5];
      m = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
      do_reset();
      for (int i = 0; i < 5; i++) w[i] = 16'($urandom_range(1, 65535));
      for (int i = 0; i < 5; i++) begin
         drive(i == 0 || i == 3, m[i], 1, w[i]);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("[TB] FAIL mode_change_model cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         if (i == 2) begin
            checks++;
            if ({out_valid, DS1_out, DS2_out, DS3_out} !== {1'b1, w[0], w[1], w[2]}) begin
               errors++; $display("[TB] FAIL mode_change_old: got %b %h %h %h expected 1 %h %h %h",
                                  out_valid, DS1_out, DS2_out, DS3_out, w[0], w[1], w[2]);
            end
         end
      end
      checks++;
      if ({out_valid, DS1_out, DS2_out, DS3_out} !== {1'b1, w[3], w[4], 16'd0}) begin
         errors++; $display("[TB] FAIL mode_change_new: got %b %h %h %h expected 1 %h %h 0",
                            out_valid, DS1_out, DS2_out, DS3_out, w[3], w[4]);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] w [8];
      do_reset();
      for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
      for (int i = 0; i < 8; i++) begin
         drive(i == 0 || i == 3, 2'b10, 2, w[i]);
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("[TB] FAIL b2b_model cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         if (i == 3) begin
            checks++;
            if (dut_vec !== {1'b1, 2'd0, w[1], w[3], 16'd0}) begin
               errors++; $display("[TB] FAIL b2b_capture: got %h expected %h", dut_vec, {1'b1, 2'd0, w[1], w[3], 16'd0});
            end
         end
      end
   endtask

   task automatic test_mode_zero();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(i == 0 || i == 2, (i == 2) ? 2'b00 : 2'b11, 2, 16'($urandom));
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("[TB] FAIL mode_zero_model cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         if (i >= 2) begin
            checks++;
            if ({out_valid, slot_idx} !== 3'b000) begin
               errors++; $display("[TB] FAIL mode_zero_idle cyc %0d: got valid=%b slot=%0d expected 0 0", i, out_valid, slot_idx);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 9; i++) drive(i == 0 || i == 6, 2'b11, 2, 16'($urandom_range(1, 65535)));
      checks++;
      if (slot_idx !== 2'd1) begin
         errors++; $display("[TB] FAIL reset_mid_slot: got %0d expected 1", slot_idx);
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_vec !== 51'd0) begin
         errors++; $display("[TB] FAIL reset_mid_clear: got %h expected 0", dut_vec);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(i == 4, 2'b11, 2, 16'($urandom));
         checks++;
         if ({out_valid, dut_vec} !== {i == 9, exp_vec()}) begin
            errors++; $display("[TB] FAIL reset_mid_resume cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      bit         s;
      logic [1:0] m;
      for (int i = 0; i < 600; i++) begin
         s = ($urandom_range(0, 4) == 0);
         m = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         drive(s, m, $urandom_range(0, 3), 16'($urandom));
         checks++;
         if (dut_vec !== exp_vec()) begin
            errors++; $display("[TB] FAIL random cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_two_streams();
      test_three_streams();
      test_zero_len();
      test_early_strobe();
      test_mode_change();
      test_back_to_back();
      test_mode_zero();
      test_reset_mid();
      do_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
